uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver for the UART/Bluetooth/LCD datapath. Next generation of the 8N1 receiver.
- Adds configurable data width, oversample ratio, parity and stop-bit count.
- Adds an input synchroniser, start-bit glitch rejection, parity/framing error flags, and a valid/ready output handshake with overrun detection.
- Sits between the shared baud-tick generator and the command/LCD consumer.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, sent LSB first.
- OVERSAMPLE, 16: tick periods per bit; must be even and >= 8.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
- rx  in  1  asynchronous serial line; idle high.
- data_out  out  DATA_BITS  received word; held while valid.
- valid  out  1  data_out and the error flags hold an unconsumed frame.
- ready_in  in  1  consumer accepts on clk edge with valid && ready_in.
- parity_err  out  1  parity mismatch for the held frame; 0 when PARITY_MODE=0.
- frame_err  out  1  a stop bit was sampled low for the held frame.
- overrun  out  1  one-clk pulse: a frame completed while valid was high and not accepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; counters=0; shift register=0.
  - Synchroniser flops=1.
  - data_out=0; valid=0; parity_err=0; frame_err=0; overrun=0; busy=0.
  - Reset mid-frame abandons the frame with no output.
- rx passes through a 2-flop synchroniser (rx_s) before any use.
- Sample counter advances only on tick. Bit counter width is clog2(DATA_BITS+1).
- States:
  - IDLE, on tick with rx_s==0: go to START, sample_cnt=0.
  - START, at sample_cnt==OVERSAMPLE/2-1:
    - rx_s==1: glitch; return to IDLE with no flags.
    - rx_s==0: go to DATA with sample_cnt=0, bit_cnt=0.
  - DATA: at sample_cnt==OVERSAMPLE-1, shift the bit in LSB first. After DATA_BITS bits go to PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: sample at OVERSAMPLE-1.
    - Odd mode: error if XOR(data, parity bit)==0.
    - Even mode: error if XOR(data, parity bit)==1.
  - STOP: sample each of STOP_BITS bits at OVERSAMPLE-1. Any low sample sets the frame's frame_err. After the last stop sample the frame completes:
    - No frame error: go to IDLE (mid-stop-bit), which allows back-to-back frames.
    - Frame error: go to BRK_WAIT.
  - BRK_WAIT: stay until a tick with rx_s==1, then go to IDLE. This prevents false starts during a break.
- Completion and output latency:
  - data_out, parity_err and frame_err load, and valid rises, on the clk edge of the tick that samples the last stop bit.
  - rx-to-valid latency is 2 clk (synchroniser) plus frame ticks.
  - Frames with errors are still delivered, with their flags set.
- Handshake:
  - valid && ready_in on an edge with no completion: valid=0 next cycle. data_out and flags hold their values until the next load.
  - Completion while valid=1 and ready_in=0: the new frame is discarded, the held frame is kept, and overrun pulses for 1 clk.
  - Completion on the same edge as acceptance: the new frame loads, valid stays 1, and there is no overrun.
- ready_in is ignored while valid=0.
- When tick=0 the FSM holds; handshake logic still runs every clk.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit (start, data, parity, stop) is sampled on the ticks at counter values mid-1, mid and mid+1.
    - mid = OVERSAMPLE/2-1 for start.
    - mid = OVERSAMPLE-1 for the other bits, relative to the bit-centre alignment established by start.
  - The bit value is the 2-of-3 majority.
  - Start rejection uses the majority.
- Undefined: single sample at the stated counter value; no extra registers.

Test Plan:
- Defaults, tick every clk, rx sends 0xA5 8N1, ready_in=1 -> valid pulses 1 clk; data_out=0xA5; parity_err=0; frame_err=0.
- Low pulse on rx of 4 ticks, then high -> FSM returns to IDLE; valid never rises; busy falls within 9 ticks.
- PARITY_MODE=2, frames 0x3C with parity bit 0, then 0x3D with parity bit 0 -> first parity_err=0; second parity_err=1; both delivered.
- 0x55 sent with stop bit low, rx then held low 40 ticks, then 0x12 -> frame_err=1 with 0x55; no frame during the low period; 0x12 received clean.
- ready_in=0, frames 0x11 then 0x22 sent -> data_out stays 0x11; overrun pulses 1 clk at the 0x22 stop sample. Then ready_in=1 -> valid falls.
- rst asserted mid-DATA of 0x77, released, then 0x88 sent -> all outputs 0 during reset; only 0x88 delivered.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver (DATA_BITS, OVERSAMPLE, parity, stop bits).
//
// Ports:
//   clk        in   system clock, all logic rising-edge
//   rst        in   asynchronous active-high reset
//   tick       in   one-clk pulse at OVERSAMPLE x baud; the FSM only moves on tick
//   rx         in   asynchronous serial line, idle high (2-flop synchronised internally)
//   data_out   out  received word, held while valid and until the next load
//   valid      out  data_out / parity_err / frame_err hold an unconsumed frame
//   ready_in   in   consumer accepts on a clk edge with valid && ready_in
//   parity_err out  parity mismatch of the held frame (always 0 when PARITY_MODE=0)
//   frame_err  out  a stop bit of the held frame was sampled low
//   overrun    out  one-clk pulse: a frame completed while a held frame was not accepted
//   busy       out  FSM is outside IDLE
//
// Optional build macro UART_RX_MAJORITY_EN: each bit is taken as the 2-of-3 majority of
// the samples at counter values mid-1, mid and mid+1; the decision is made at mid+1.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready_in,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [1:0] PMODE = 2'(PARITY_MODE);

`ifdef UART_RX_MAJORITY_EN
    // Decision one tick after the bit centre; reloading with 1 keeps the next
    // centre exactly OVERSAMPLE ticks after this one.
    localparam logic [CW-1:0] START_DEC  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] BIT_DEC    = CW'(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(1);
`else
    localparam logic [CW-1:0] START_DEC  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_DEC    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(0);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    // Parity error for a completed frame: odd mode wants XOR==1, even mode wants XOR==0.
    function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = ^{d, p};
        case (PMODE)
            2'd1:    return ~x;
            2'd2:    return x;
            default: return 1'b0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   rx_meta_q, rx_sync_q;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;

    logic                   rx_s;
    logic                   bit_s;
    logic [CW-1:0]          dec_s;
    logic                   at_dec_s;
    logic                   done_s;
    logic                   done_ferr_s;

    assign rx_s     = rx_sync_q;
    assign dec_s    = (state_q == S_START) ? START_DEC : BIT_DEC;
    assign at_dec_s = (cnt_q == dec_s);

`ifdef UART_RX_MAJORITY_EN
    logic hist0_q, hist0_d, hist1_q, hist1_d;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign bit_s = maj3(hist0_q, hist1_q, rx_s);

    // Capture the two samples preceding the decision tick.
    always_comb begin
        hist0_d = hist0_q;
        hist1_d = hist1_q;
        if (tick && (cnt_q == dec_s - CW'(2))) begin
            hist0_d = rx_s;
        end else if (tick && (cnt_q == dec_s - CW'(1))) begin
            hist1_d = rx_s;
        end else begin
            hist0_d = hist0_q;
        end
    end

    // Majority history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist0_q <= 1'b1;
            hist1_q <= 1'b1;
        end else begin
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
        end
    end
`else
    assign bit_s = rx_s;
`endif

    // Receive FSM next-state logic; everything advances only on tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        ferr_acc_d  = ferr_acc_q;
        done_s      = 1'b0;
        done_ferr_s = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (!at_dec_s) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (bit_s) begin
                        state_d = S_IDLE;   // glitch, not a start bit
                        cnt_d   = '0;
                    end else begin
                        state_d    = S_DATA;
                        cnt_d      = CNT_RELOAD;
                        bit_cnt_d  = '0;
                        ferr_acc_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (!at_dec_s) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        shift_d = {bit_s, shift_q[DATA_BITS-1:1]};   // LSB first
                        cnt_d   = CNT_RELOAD;
                        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PMODE != 2'd0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (!at_dec_s) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        par_bit_d = bit_s;
                        cnt_d     = CNT_RELOAD;
                        state_d   = S_STOP;
                    end
                end
                S_STOP: begin
                    if (!at_dec_s) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        // Last stop sample: frame completes here, mid stop bit.
                        done_s      = 1'b1;
                        done_ferr_s = ferr_acc_q | ~bit_s;
                        cnt_d       = '0;
                        bit_cnt_d   = '0;
                        state_d     = (ferr_acc_q | ~bit_s) ? S_BRK : S_IDLE;
                    end else begin
                        ferr_acc_d = ferr_acc_q | ~bit_s;
                        cnt_d      = CNT_RELOAD;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                    end
                end
                S_BRK: begin
                    // Wait for the line to return high so a break is not a new start.
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BRK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output handshake: load, accept, or flag overrun; runs every clk.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        busy_d  = (state_d != S_IDLE);
        if (done_s) begin
            if (valid_q && !ready_in) begin
                ovr_d = 1'b1;   // held frame kept, new one dropped
            end else begin
                data_d  = shift_q;
                perr_d  = parity_err_f(shift_q, par_bit_q);
                ferr_d  = done_ferr_s;
                valid_d = 1'b1;
            end
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, datapath, synchroniser and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            ferr_acc_q <= ferr_acc_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: instance A uses the defaults (8N1, x16), instance B uses
// even parity, two stop bits, x8 oversampling. Frames are built bit by bit from their
// field values and the received words are compared with what was sent.
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic ready_a, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic valid_a, valid_b, pe_a, pe_b, fe_a, fe_b, ovr_a, ovr_b, busy_a, busy_b;

    uart_rx_param dut_a (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_a), .data_out(data_a), .valid(valid_a),
        .ready_in(ready_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_b), .data_out(data_b), .valid(valid_b),
        .ready_in(ready_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ovr_b), .busy(busy_b)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    typedef struct packed {
        logic [7:0] d;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    frame_t got_a[$], got_b[$];
    int     ovr_cnt_a = 0, ovr_cnt_b = 0, vrise_a = 0;
    int     total = 0, bad = 0;
    bit     tick_rand = 1'b0, ready_rand = 1'b0;
    logic   ready_a_fix = 1'b1;

    // tick and ready_a change just after each rising edge
    initial begin
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick    = tick_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            ready_a = ready_rand ? 1'($urandom_range(0, 1)) : ready_a_fix;
        end
    end

    // collect accepted frames, overrun pulses and valid rises (mid-cycle)
    initial begin
        logic vprev;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid_a && ready_a) got_a.push_back({data_a, pe_a, fe_a});
                if (valid_b && ready_b) got_b.push_back({data_b, pe_b, fe_b});
                if (ovr_a) ovr_cnt_a++;
                if (ovr_b) ovr_cnt_b++;
                if (valid_a && !vprev) vrise_a++;
            end
            vprev = valid_a;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
    endtask

    // hold the line at v for n ticks; returns just after the last tick edge
    task automatic drive_bit(input int which, input logic v, input int n);
        if (which == 0) rx_a = v;
        else rx_b = v;
        repeat (n) wait_tick();
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input int os,
                              input bit use_par, input logic pbit, input int nstop,
                              input logic s1, input logic s2);
        drive_bit(which, 1'b0, os);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], os);
        if (use_par) drive_bit(which, pbit, os);
        drive_bit(which, s1, os);
        if (nstop == 2) drive_bit(which, s2, os);
    endtask

    task automatic expect_frame(input int which, input string nm, input logic [7:0] d,
                                input logic pe, input logic fe);
        frame_t f;
        int     c;
        c = 0;
        while (((which == 0) ? got_a.size() : got_b.size()) == 0 && c < 4000) begin
            @(posedge clk);
            c++;
        end
        if (((which == 0) ? got_a.size() : got_b.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no frame received within %0d clk", nm, c);
        end else begin
            f = (which == 0) ? got_a.pop_front() : got_b.pop_front();
            check({nm, ".data"}, 32'(f.d), 32'(d));
            check({nm, ".parity_err"}, 32'(f.pe), 32'(pe));
            check({nm, ".frame_err"}, 32'(f.fe), 32'(fe));
        end
    endtask

    initial begin
        vec_t   tbl[8];
        frame_t model_q[$];
        frame_t e;
        int     v0, o0;

        tbl[0] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3D, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.data_a", 32'(data_a), 32'h0);
        check("rst.valid_a", 32'(valid_a), 32'h0);
        check("rst.pe_a", 32'(pe_a), 32'h0);
        check("rst.fe_a", 32'(fe_a), 32'h0);
        check("rst.ovr_a", 32'(ovr_a), 32'h0);
        check("rst.busy_a", 32'(busy_a), 32'h0);
        check("rst.valid_b", 32'(valid_b), 32'h0);
        check("rst.busy_b", 32'(busy_b), 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // 0xA5 8N1, exact latency and one-clk valid
        fork
            send_frame(0, 8'hA5, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
            begin
                int n;
                n = 0;
                while (valid_a !== 1'b1 && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("a5.latency", 32'(n), 32'd155);
                @(posedge clk);
                #1;
                check("a5.valid_one_clk", 32'(valid_a), 32'h0);
            end
        join
        drive_bit(0, 1'b1, 16);
        expect_frame(0, "a5", 8'hA5, 1'b0, 1'b0);
        check("a5.valid_rises", 32'(vrise_a), 32'd1);

        // 4-tick glitch on the line
        v0 = vrise_a;
        drive_bit(0, 1'b0, 4);
        check("glitch.busy_high", 32'(busy_a), 32'h1);
        rx_a = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("glitch.busy_low", 32'(busy_a), 32'h0);
        repeat (200) @(posedge clk);
        #1;
        check("glitch.no_valid", 32'(vrise_a - v0), 32'h0);
        check("glitch.no_frame", 32'(got_a.size()), 32'h0);

        // even parity, two stop bits, table of vectors
        for (int i = 0; i < 8; i++) begin
            send_frame(1, tbl[i].d, 8, 1'b1, tbl[i].pbit, 2, tbl[i].s1, tbl[i].s2);
            drive_bit(1, 1'b1, 16);
            expect_frame(1, $sformatf("tbl%0d", i), tbl[i].d, tbl[i].exp_pe, tbl[i].exp_fe);
        end

        // break: 0x55 with low stop bit, line low 40 ticks, then clean 0x12
        send_frame(0, 8'h55, 16, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        drive_bit(0, 1'b0, 40);
        drive_bit(0, 1'b1, 32);
        send_frame(0, 8'h12, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        drive_bit(0, 1'b1, 32);
        expect_frame(0, "brk55", 8'h55, 1'b0, 1'b1);
        expect_frame(0, "after_brk12", 8'h12, 1'b0, 1'b0);
        check("brk.no_extra", 32'(got_a.size()), 32'h0);

        // overrun: consumer stalled across two frames
        ready_a_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o0 = ovr_cnt_a;
        send_frame(0, 8'h11, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        drive_bit(0, 1'b1, 16);
        send_frame(0, 8'h22, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        drive_bit(0, 1'b1, 32);
        check("ovr.valid_held", 32'(valid_a), 32'h1);
        check("ovr.data_held", 32'(data_a), 32'h11);
        check("ovr.pulses", 32'(ovr_cnt_a - o0), 32'd1);
        ready_a_fix = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovr.valid_falls", 32'(valid_a), 32'h0);
        expect_frame(0, "ovr11", 8'h11, 1'b0, 1'b0);
        check("ovr.dropped22", 32'(got_a.size()), 32'h0);

        // reset mid-DATA of 0x77, then 0x88
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 16);
        rst  = 1'b1;
        rx_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst.data", 32'(data_a), 32'h0);
        check("midrst.valid", 32'(valid_a), 32'h0);
        check("midrst.flags", 32'({pe_a, fe_a, ovr_a}), 32'h0);
        check("midrst.busy", 32'(busy_a), 32'h0);
        rst = 1'b0;
        drive_bit(0, 1'b1, 32);
        send_frame(0, 8'h88, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        drive_bit(0, 1'b1, 32);
        expect_frame(0, "post_rst88", 8'h88, 1'b0, 1'b0);
        check("midrst.only88", 32'(got_a.size()), 32'h0);

        // randomised frames, sparse ticks, random consumer
        tick_rand  = 1'b1;
        ready_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            logic [7:0] d;
            logic       bs;
            d  = 8'($urandom);
            bs = ($urandom_range(0, 4) == 0);
            model_q.push_back('{d, 1'b0, bs});
            send_frame(0, d, 16, 1'b0, 1'b0, 1, ~bs, 1'b1);
            drive_bit(0, 1'b1, 16 * $urandom_range(1, 3));
            e = model_q.pop_front();
            expect_frame(0, $sformatf("rndA%0d", i), e.d, e.pe, e.fe);
        end
        for (int i = 0; i < 15; i++) begin
            logic [7:0] d;
            logic       p, s1, s2;
            d  = 8'($urandom);
            p  = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            // even parity: the data bits plus parity bit must hold an even count of ones
            model_q.push_back('{d, 1'($countones(d) + 32'(p)), ~(s1 & s2)});
            send_frame(1, d, 8, 1'b1, p, 2, s1, s2);
            drive_bit(1, 1'b1, 8 * $urandom_range(2, 3));
            e = model_q.pop_front();
            expect_frame(1, $sformatf("rndB%0d", i), e.d, e.pe, e.fe);
        end
        check("overrun_total_a", 32'(ovr_cnt_a), 32'd1);
        check("overrun_total_b", 32'(ovr_cnt_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
